multiport_register_file: RTL and testbench

Parametrised general-purpose register file for the MIPS datapath. It has a configurable number of read and write ports, a hardwired-zero register 0, and a per-register busy scoreboard for pipeline hazard detection. It replaces the fixed 2-read/1-write file in the decode stage, so a dual-issue or multi-writeback pipeline can read operands and see pending destinations in one place.

---
 rtl/multiport_register_file.sv | 110 +++++++++++
 tb/tb_multiport_register_file.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Multi-read/multi-write register file with hardwired-zero r0 and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module multiport_register_file #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int REG_SIZE      = 32,
    parameter int READ_PORTS    = 2,
    parameter int WRITE_PORTS   = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [WRITE_PORTS-1:0]                write_en,
    input  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0]  write_reg_addr,
    input  logic [WRITE_PORTS*REG_SIZE-1:0]       write_reg_data_in,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0]   read_reg_addr,
    output logic [READ_PORTS*REG_SIZE-1:0]        reg_data_out,
    output logic [READ_PORTS-1:0]                 reg_busy_out,
    input  logic                                  reserve_en,
    input  logic [ADDRESS_WIDTH-1:0]              reserve_reg_addr,
    output logic [2**ADDRESS_WIDTH-1:0]           busy_vector,
    output logic                                  write_conflict
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [REG_SIZE-1:0]      regs     [DEPTH];
    logic [REG_SIZE-1:0]      win_data [DEPTH];
    logic [DEPTH-1:0]         written;
    logic [DEPTH-1:0]         reserved;
    logic [DEPTH-1:0]         busy_next;
    logic                     conflict_next;
    logic [ADDRESS_WIDTH-1:0] wa;
    logic [ADDRESS_WIDTH-1:0] ra;
    logic [REG_SIZE-1:0]      rd;
    logic                     rb;

    // Ports are scanned low to high so a higher-indexed port overrides a lower one.
    // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        written       = '0;
        conflict_next = 1'b0;
        wa            = '0;
        for (int r = 0; r < DEPTH; r++) begin
            win_data[r] = '0;
        end
        for (int k = 0; k < WRITE_PORTS; k++) begin
            wa = write_reg_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            if (write_en[k]) begin
                if (written[wa] && wa != '0) begin
                    conflict_next = 1'b1;
                end
                written[wa]  = 1'b1;
                win_data[wa] = write_reg_data_in[k*REG_SIZE +: REG_SIZE];
            end
        end
        written[0] = 1'b0;
    end

    always_comb begin
        reserved = '0;
        if (reserve_en) begin
            reserved[reserve_reg_addr] = 1'b1;
        end
        reserved[0] = 1'b0;
        // A same-cycle reserve beats the clearing write: the new producer is still pending.
        busy_next   = reserved | (busy_vector & ~written);
    end

    // NOTE: the storage is built from flops, so it is cleared by the async reset like any other state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            busy_vector    <= '0;
            write_conflict <= 1'b0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (written[r]) begin
                    regs[r] <= win_data[r];
                end
            end
            busy_vector    <= busy_next;
            write_conflict <= conflict_next;
        end
    end

    always_comb begin
        reg_data_out = '0;
        reg_busy_out = '0;
        ra           = '0;
        rd           = '0;
        rb           = 1'b0;
        for (int j = 0; j < READ_PORTS; j++) begin
            ra = read_reg_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            rd = regs[ra];
            rb = busy_vector[ra];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is gated by reset so a held reset still reads all zeros.
            if (reset && written[ra]) begin
                rd = win_data[ra];
                rb = reserved[ra];
            end
`endif
            reg_data_out[j*REG_SIZE +: REG_SIZE] = rd;
            reg_busy_out[j]                      = rb;
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: expectations are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_multiport_register_file;

    localparam int AW    = 5;
    localparam int RS    = 32;
    localparam int RP    = 2;
    localparam int WP    = 2;
    localparam int DEPTH = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [WP-1:0]     write_en;
    logic [WP*AW-1:0]  write_reg_addr;
    logic [WP*RS-1:0]  write_reg_data_in;
    logic [RP*AW-1:0]  read_reg_addr;
    logic [RP*RS-1:0]  reg_data_out;
    logic [RP-1:0]     reg_busy_out;
    logic              reserve_en;
    logic [AW-1:0]     reserve_reg_addr;
    logic [DEPTH-1:0]  busy_vector;
    logic              write_conflict;

    multiport_register_file #(
        .ADDRESS_WIDTH(AW), .REG_SIZE(RS), .READ_PORTS(RP), .WRITE_PORTS(WP)
    ) dut (
        .clock(clock), .reset(reset),
        .write_en(write_en), .write_reg_addr(write_reg_addr),
        .write_reg_data_in(write_reg_data_in), .read_reg_addr(read_reg_addr),
        .reg_data_out(reg_data_out), .reg_busy_out(reg_busy_out),
        .reserve_en(reserve_en), .reserve_reg_addr(reserve_reg_addr),
        .busy_vector(busy_vector), .write_conflict(write_conflict)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] obs;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] busy_m;

    task automatic push(input string name, input logic [31:0] value);
        exp_t x;
        x.name  = name;
        x.value = value;
        sb.push_back(x);
    endtask

    function automatic exp_t pop_exp();
        exp_t x;
        x.name  = "scoreboard_underflow";
        x.value = 'x;
        if (sb.size() != 0) x = sb.pop_front();
        return x;
    endfunction

    function automatic logic [31:0] rdata(input int p);
        return reg_data_out[p*RS +: RS];
    endfunction

    task automatic idle();
        write_en   = '0;
        reserve_en = 1'b0;
    endtask

    task automatic set_write(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        write_en[p]                  = 1'b1;
        write_reg_addr[p*AW +: AW]   = a;
        write_reg_data_in[p*RS +: RS] = d;
    endtask

    task automatic set_read(input int p, input logic [AW-1:0] a);
        read_reg_addr[p*AW +: AW] = a;
    endtask

    task automatic set_reserve(input logic [AW-1:0] a);
        reserve_en       = 1'b1;
        reserve_reg_addr = a;
    endtask

    // Clock the staged inputs in, then idle them and sample mid-cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
        #1;
    endtask

    task automatic test_reset();
        set_read(0, 5'd5);
        set_read(1, 5'd0);
        #1 reset = 1'b0;
        #1;
        push("reset_rd0", 32'h0); push("reset_rd1", 32'h0);
        push("reset_busy_vector", 32'h0); push("reset_conflict", 32'h0);
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = rdata(1); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        // Writes and reserves must be ignored across an edge while reset is held.
        set_write(0, 5'd5, 32'hFFFF_0000);
        set_reserve(5'd5);
        push("reset_ignores_write", 32'h0); push("reset_ignores_reserve", 32'h0);
        @(posedge clock);
        #1;
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        idle();
        #1 reset = 1'b1;
    endtask

    task automatic test_write_read();
        set_write(0, 5'd5, 32'hDEAD_BEEF);
        set_read(0, 5'd5);
        set_read(1, 5'd5);
        push("wr_r5_port0", 32'hDEAD_BEEF); push("wr_r5_port1", 32'hDEAD_BEEF); push("wr_r5_conflict", 32'h0);
        tick();
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = rdata(1); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
    endtask

    task automatic test_r0();
        set_write(1, 5'd0, 32'h1234_5678);
        set_reserve(5'd0);
        set_read(0, 5'd0);
        set_read(1, 5'd0);
        push("r0_port0", 32'h0); push("r0_port1", 32'h0);
        push("r0_busy_vector", 32'h0); push("r0_conflict", 32'h0);
        tick();
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = rdata(1); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
    endtask

    task automatic test_conflict();
        set_write(0, 5'd7, 32'h1);
        set_write(1, 5'd7, 32'h2);
        set_read(0, 5'd7);
        push("conflict_r7_data", 32'h2); push("conflict_flag_set", 32'h1);
        tick();
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        push("conflict_flag_one_cycle", 32'h0);
        tick();
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        set_write(0, 5'd0, 32'h3);
        set_write(1, 5'd0, 32'h4);
        push("conflict_r0_no_flag", 32'h0);
        tick();
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        set_write(0, 5'd10, 32'hAAAA_0010);
        set_write(1, 5'd11, 32'hBBBB_0011);
        set_read(0, 5'd10);
        set_read(1, 5'd11);
        push("distinct_r10", 32'hAAAA_0010); push("distinct_r11", 32'hBBBB_0011); push("distinct_no_flag", 32'h0);
        tick();
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = rdata(1); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
    endtask

    task automatic test_scoreboard();
        set_reserve(5'd9);
        set_read(0, 5'd9);
        push("reserve_r9_vector", 32'h0000_0200); push("reserve_r9_port_busy", 32'h1);
        tick();
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(reg_busy_out[0]); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        set_write(1, 5'd9, 32'h99);
        set_reserve(5'd9);
        push("write_and_reserve_r9", 32'h0000_0200);
        tick();
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        set_write(0, 5'd9, 32'h9999);
        set_reserve(5'd0);
        push("write_clears_r9", 32'h0); push("write_r9_data", 32'h9999);
        tick();
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
    endtask

    task automatic test_bypass();
        set_write(0, 5'd3, 32'h1111_1111);
        set_reserve(5'd3);
        push("bypass_setup_busy", 32'h0000_0008);
        tick();
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        set_write(0, 5'd3, 32'hA5A5_A5A5);
        set_read(0, 5'd3);
        set_read(1, 5'd3);
`ifdef REGFILE_BYPASS_EN
        push("same_cycle_read_r3", 32'hA5A5_A5A5); push("same_cycle_busy_r3", 32'h0);
`else
        push("same_cycle_read_r3", 32'h1111_1111); push("same_cycle_busy_r3", 32'h1);
`endif
        #1;
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(reg_busy_out[1]); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        push("next_cycle_read_r3", 32'hA5A5_A5A5); push("next_cycle_busy_r3", 32'h0);
        tick();
        obs = rdata(1); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(reg_busy_out[0]); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
    endtask

    task automatic test_reset_mid();
        set_write(0, 5'd1, 32'h0000_0101);
        set_write(1, 5'd2, 32'h0000_0202);
        set_reserve(5'd2);
        tick();
        set_write(0, 5'd3, 32'h0000_0303);
        set_write(1, 5'd4, 32'h0000_0404);
        tick();
        set_write(0, 5'd4, 32'h0000_0444);
        set_write(1, 5'd4, 32'h0000_0455);
        set_read(0, 5'd4);
        set_read(1, 5'd2);
        push("loaded_r4", 32'h0000_0455); push("loaded_busy", 32'h0000_0004); push("loaded_conflict", 32'h1);
        tick();
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        // Assert reset between edges; outputs must clear with no clock edge.
        #2 reset = 1'b0;
        push("async_rd_r4", 32'h0); push("async_port_busy", 32'h0);
        push("async_busy_vector", 32'h0); push("async_conflict", 32'h0);
        #1;
        obs = rdata(0); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(reg_busy_out); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = busy_vector; e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        obs = 32'(write_conflict); e = pop_exp(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        #3 reset = 1'b1;
        for (int r = 1; r <= 5; r += 2) begin
            set_read(0, AW'(r));
            set_read(1, AW'(r + 1));
            push($sformatf("after_release_r%0d", r), 32'h0);
            push($sformatf("after_release_r%0d", r + 1), 32'h0);
            #1;
            obs = rdata(0); e = pop_exp(); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
            obs = rdata(1); e = pop_exp(); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]    en;
        logic [AW-1:0] a0, a1, ra;
        logic [31:0]   d0, d1, wr;
        logic          resv;
        for (int r = 0; r < DEPTH; r++) mem_m[r] = 32'h0;
        busy_m = 32'h0;
        for (int i = 0; i < 20; i++) begin
            en   = 2'($urandom_range(0, 3));
            a0   = AW'($urandom_range(0, DEPTH - 1));
            a1   = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, DEPTH - 1));
            d0   = $urandom;
            d1   = $urandom;
            resv = 1'($urandom_range(0, 1));
            ra   = AW'($urandom_range(0, DEPTH - 1));
            wr   = 32'h0;
            if (en[0]) set_write(0, a0, d0);
            if (en[1]) set_write(1, a1, d1);
            if (resv) set_reserve(ra);
            if (en[0] && a0 != 0) begin mem_m[a0] = d0; wr[a0] = 1'b1; end
            if (en[1] && a1 != 0) begin mem_m[a1] = d1; wr[a1] = 1'b1; end
            busy_m = busy_m & ~wr;
            if (resv && ra != 0) busy_m[ra] = 1'b1;
            push($sformatf("b2b_conflict_%0d", i), 32'(en == 2'b11 && a0 == a1 && a0 != 0));
            push($sformatf("b2b_busy_%0d", i), busy_m);
            tick();
            obs = 32'(write_conflict); e = pop_exp(); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
            obs = busy_vector; e = pop_exp(); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
        for (int r = 0; r < DEPTH; r += 2) begin
            set_read(0, AW'(r));
            set_read(1, AW'(r + 1));
            push($sformatf("readback_r%0d", r), mem_m[r]);
            push($sformatf("readback_r%0d", r + 1), mem_m[r + 1]);
            push($sformatf("readback_busy_r%0d", r), {30'h0, busy_m[r + 1], busy_m[r]});
            #1;
            obs = rdata(0); e = pop_exp(); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
            obs = rdata(1); e = pop_exp(); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
            obs = 32'(reg_busy_out); e = pop_exp(); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    initial begin
        write_en          = '0;
        write_reg_addr    = '0;
        write_reg_data_in = '0;
        read_reg_addr     = '0;
        reserve_en        = 1'b0;
        reserve_reg_addr  = '0;
        test_reset();
        test_write_read();
        test_r0();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_reset_mid();
        test_back_to_back();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
